// File: rtl/dma_utils_pkg.sv
// Shared DMA helpers: default geometry macros and FIFO counter sizing.
`ifndef DMA_FIFO_DEPTH
`define DMA_FIFO_DEPTH 8
`endif
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 64
`endif

package dma_utils_pkg;

    function automatic int fifo_cnt_w(input int cap);
        return $clog2(cap + 1);
    endfunction

    function automatic int fifo_ptr_w(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/dma_fifo_out_stage.sv
// Single-entry valid/ready register used as the optional FIFO output stage.
module dma_fifo_out_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             vld;
    logic [WIDTH-1:0] data;

    assign in_ready  = ~vld | out_ready;
    assign out_valid = vld;
    assign out_data  = data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (flush_i) begin
            vld <= 1'b0;
        end else if (in_ready) begin
            vld <= in_valid;
            if (in_valid) data <= in_data;
        end
    end

endmodule

// File: rtl/dma_fifo_hs.sv
// DMA data buffer with ready/valid on both sides, any depth >= 2,
// optional registered output, programmable level flags and flush.
module dma_fifo_hs
    import dma_utils_pkg::*;
#(
    parameter int SLOTS     = `DMA_FIFO_DEPTH,
    parameter int WIDTH     = `DMA_DATA_WIDTH,
    parameter int OUT_REG   = 0,
    parameter int AF_THRESH = SLOTS + OUT_REG - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush_i,
    input  logic                                   wr_valid_i,
    output logic                                   wr_ready_o,
    input  logic [WIDTH-1:0]                       wr_data_i,
    output logic                                   rd_valid_o,
    input  logic                                   rd_ready_i,
    output logic [WIDTH-1:0]                       rd_data_o,
    output logic                                   full_o,
    output logic                                   empty_o,
    output logic                                   almost_full_o,
    output logic                                   almost_empty_o,
    output logic [fifo_cnt_w(SLOTS+OUT_REG)-1:0]   ocup_o,
    output logic [fifo_cnt_w(SLOTS+OUT_REG)-1:0]   free_o
);

    localparam int CAP = SLOTS + OUT_REG;
    localparam int PW  = fifo_ptr_w(SLOTS);
    localparam int CW  = fifo_cnt_w(SLOTS);
    localparam int OW  = fifo_cnt_w(CAP);

    localparam logic [PW-1:0] LAST  = PW'(SLOTS - 1);
    localparam logic [OW-1:0] CAP_V = OW'(CAP);
    localparam logic [OW-1:0] AF_V  = OW'(AF_THRESH);
    localparam logic [OW-1:0] AE_V  = OW'(AE_THRESH);

`ifndef NO_ASSERTIONS
    if (SLOTS < 2) begin : g_bad_slots
        $error("dma_fifo_hs: SLOTS must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > CAP) begin : g_bad_af
        $error("dma_fifo_hs: AF_THRESH out of range 1..CAP");
    end
    if (AE_THRESH < 0 || AE_THRESH >= CAP) begin : g_bad_ae
        $error("dma_fifo_hs: AE_THRESH out of range 0..CAP-1");
    end
`endif

    logic [WIDTH-1:0] mem [SLOTS];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             arr_vld;
    logic             push;
    logic             pop;
    logic             stage_vld;
    logic [WIDTH-1:0] head;

    assign arr_vld    = (count != '0);
    assign full_o     = (ocup_o == CAP_V);
    assign wr_ready_o = rst & ~full_o & ~flush_i;
    assign push       = wr_valid_i & wr_ready_o;

    if (OUT_REG != 0) begin : g_oreg
        logic in_ready;

        dma_fifo_out_stage #(
            .WIDTH (WIDTH)
        ) u_out (
            .clk       (clk),
            .rst       (rst),
            .flush_i   (flush_i),
            .in_valid  (arr_vld),
            .in_ready  (in_ready),
            .in_data   (mem[rd_ptr]),
            .out_valid (stage_vld),
            .out_ready (rd_ready_i),
            .out_data  (head)
        );

        assign pop        = arr_vld & in_ready & ~flush_i;
        assign rd_valid_o = stage_vld;
    end else begin : g_ft
        assign stage_vld  = 1'b0;
        assign head       = mem[rd_ptr];
        assign rd_valid_o = arr_vld;
        assign pop        = arr_vld & rd_ready_i & ~flush_i;
    end

    // Gate the head so idle cycles never leak stale array contents.
    assign rd_data_o = rd_valid_o ? head : '0;

    assign ocup_o         = OW'(count) + OW'(stage_vld);
    assign free_o         = CAP_V - ocup_o;
    assign empty_o        = (ocup_o == '0);
    assign almost_full_o  = (ocup_o >= AF_V);
    assign almost_empty_o = (ocup_o <= AE_V);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            if (push & ~pop)      count <= count + CW'(1);
            else if (pop & ~push) count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_dma_fifo_hs.sv
// Directed bench: fall-through FIFO (SLOTS=5) and registered-output FIFO (SLOTS=4).
module tb_dma_fifo_hs;

    logic clk;
    logic rst;

    logic        a_flush, a_wr_valid, a_wr_ready, a_rd_valid, a_rd_ready;
    logic [31:0] a_wr_data, a_rd_data;
    logic        a_full, a_empty, a_afull, a_aempty;
    logic [2:0]  a_ocup, a_free;

    logic        b_flush, b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready;
    logic [31:0] b_wr_data, b_rd_data;
    logic        b_full, b_empty, b_afull, b_aempty;
    logic [2:0]  b_ocup, b_free;

    int n_chk  = 0;
    int n_fail = 0;

    dma_fifo_hs #(
        .SLOTS (5), .WIDTH (32), .OUT_REG (0)
    ) u_a (
        .clk (clk), .rst (rst), .flush_i (a_flush),
        .wr_valid_i (a_wr_valid), .wr_ready_o (a_wr_ready),
        .wr_data_i (a_wr_data), .rd_valid_o (a_rd_valid),
        .rd_ready_i (a_rd_ready), .rd_data_o (a_rd_data),
        .full_o (a_full), .empty_o (a_empty),
        .almost_full_o (a_afull), .almost_empty_o (a_aempty),
        .ocup_o (a_ocup), .free_o (a_free)
    );

    dma_fifo_hs #(
        .SLOTS (4), .WIDTH (32), .OUT_REG (1)
    ) u_b (
        .clk (clk), .rst (rst), .flush_i (b_flush),
        .wr_valid_i (b_wr_valid), .wr_ready_o (b_wr_ready),
        .wr_data_i (b_wr_data), .rd_valid_o (b_rd_valid),
        .rd_ready_i (b_rd_ready), .rd_data_o (b_rd_data),
        .full_o (b_full), .empty_o (b_empty),
        .almost_full_o (b_afull), .almost_empty_o (b_aempty),
        .ocup_o (b_ocup), .free_o (b_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Output-side protocol monitor, sampled on the falling edge.
    logic        a_pv, a_pr, a_pf, a_prst;
    logic        b_pv, b_pr, b_pf, b_prst;
    logic [31:0] a_pd, b_pd;
    initial begin
        a_pv = 0; a_pr = 0; a_pf = 0; a_prst = 0; a_pd = 0;
        b_pv = 0; b_pr = 0; b_pf = 0; b_prst = 0; b_pd = 0;
    end

    always @(negedge clk) begin
        if (rst && a_prst && a_pv && !a_pr && !a_pf) begin
            chk("a_hold_valid", 32'(a_rd_valid), 32'd1);
            chk("a_hold_data", a_rd_data, a_pd);
        end
        if (rst && b_prst && b_pv && !b_pr && !b_pf) begin
            chk("b_hold_valid", 32'(b_rd_valid), 32'd1);
            chk("b_hold_data", b_rd_data, b_pd);
        end
        if (!a_rd_valid) chk("a_idle_data", a_rd_data, 32'd0);
        if (!b_rd_valid) chk("b_idle_data", b_rd_data, 32'd0);
        a_pv = a_rd_valid; a_pr = a_rd_ready; a_pf = a_flush;
        a_prst = rst; a_pd = a_rd_data;
        b_pv = b_rd_valid; b_pr = b_rd_ready; b_pf = b_flush;
        b_prst = rst; b_pd = b_rd_data;
    end

    initial begin
        rst = 0;
        a_flush = 0; a_wr_valid = 0; a_rd_ready = 0; a_wr_data = 0;
        b_flush = 0; b_wr_valid = 0; b_rd_ready = 0; b_wr_data = 0;

        // reset / idle
        repeat (2) @(posedge clk);
        #2;
        chk("rst_a_wr_ready", 32'(a_wr_ready), 32'd0);
        chk("rst_a_rd_valid", 32'(a_rd_valid), 32'd0);
        chk("rst_a_empty", 32'(a_empty), 32'd1);
        chk("rst_a_full", 32'(a_full), 32'd0);
        chk("rst_a_ocup", 32'(a_ocup), 32'd0);
        chk("rst_a_free", 32'(a_free), 32'd5);
        chk("rst_a_aempty", 32'(a_aempty), 32'd1);
        chk("rst_b_free", 32'(b_free), 32'd5);
        chk("rst_b_wr_ready", 32'(b_wr_ready), 32'd0);
        rst = 1;
        tick();
        chk("rel_a_wr_ready", 32'(a_wr_ready), 32'd1);
        chk("rel_b_wr_ready", 32'(b_wr_ready), 32'd1);

        // A: fill to full across a non-power-of-2 depth
        a_wr_valid = 1;
        for (int i = 0; i < 5; i++) begin
            a_wr_data = 32'hA0 + 32'(i);
            tick();
            chk("fill_ocup", 32'(a_ocup), 32'(i + 1));
            chk("fill_afull", 32'(a_afull), 32'(i + 1 >= 4));
            chk("fill_aempty", 32'(a_aempty), 32'(i + 1 <= 1));
            chk("fill_full", 32'(a_full), 32'(i == 4));
        end
        chk("full_wr_ready", 32'(a_wr_ready), 32'd0);
        chk("full_free", 32'(a_free), 32'd0);
        a_wr_data = 32'hA5;
        tick();
        chk("full_drop_ocup", 32'(a_ocup), 32'd5);
        chk("full_head", a_rd_data, 32'hA0);

        a_wr_valid = 0;
        a_rd_ready = 1;
        for (int i = 0; i < 3; i++) begin
            chk("rd3_data", a_rd_data, 32'hA0 + 32'(i));
            tick();
        end
        chk("rd3_ocup", 32'(a_ocup), 32'd2);

        a_rd_ready = 0;
        a_wr_valid = 1;
        for (int i = 0; i < 3; i++) begin
            a_wr_data = 32'hA5 + 32'(i);
            tick();
        end
        a_wr_valid = 0;
        chk("wrap_full", 32'(a_full), 32'd1);

        a_rd_ready = 1;
        for (int i = 0; i < 5; i++) begin
            chk("wrap_valid", 32'(a_rd_valid), 32'd1);
            chk("wrap_data", a_rd_data, 32'hA3 + 32'(i));
            tick();
        end
        a_rd_ready = 0;
        chk("drain_empty", 32'(a_empty), 32'd1);
        chk("drain_valid", 32'(a_rd_valid), 32'd0);

        // A: simultaneous write and read at ocup=3
        a_wr_valid = 1;
        for (int i = 0; i < 3; i++) begin
            a_wr_data = 32'hB0 + 32'(i);
            tick();
        end
        chk("sim_pre_ocup", 32'(a_ocup), 32'd3);
        a_rd_ready = 1;
        for (int i = 0; i < 10; i++) begin
            a_wr_data = 32'hB3 + 32'(i);
            chk("sim_data", a_rd_data, 32'hB0 + 32'(i));
            tick();
            chk("sim_ocup", 32'(a_ocup), 32'd3);
        end
        a_rd_ready = 0;
        a_wr_data = 32'hC0;
        tick();
        a_wr_data = 32'hC1;
        tick();
        chk("sim_full", 32'(a_full), 32'd1);
        a_rd_ready = 1;
        a_wr_data = 32'hEE;
        chk("full_rd_wr_ready", 32'(a_wr_ready), 32'd0);
        chk("full_rd_head", a_rd_data, 32'hBA);
        tick();
        chk("full_rd_ocup", 32'(a_ocup), 32'd4);
        chk("full_rd_next", a_rd_data, 32'hBB);
        a_wr_valid = 0;
        tick();
        a_rd_ready = 0;
        chk("pre_flush_ocup", 32'(a_ocup), 32'd3);
        chk("pre_flush_head", a_rd_data, 32'hBC);

        // A: flush with a concurrent write
        a_flush = 1;
        a_wr_valid = 1;
        a_wr_data = 32'hDD;
        #1;
        chk("flush_wr_ready", 32'(a_wr_ready), 32'd0);
        tick();
        a_flush = 0;
        a_wr_valid = 0;
        chk("flush_ocup", 32'(a_ocup), 32'd0);
        chk("flush_empty", 32'(a_empty), 32'd1);
        chk("flush_valid", 32'(a_rd_valid), 32'd0);
        a_wr_valid = 1;
        a_wr_data = 32'h77;
        tick();
        a_wr_valid = 0;
        chk("post_flush_head", a_rd_data, 32'h77);
        chk("post_flush_ocup", 32'(a_ocup), 32'd1);
        a_rd_ready = 1;
        tick();
        a_rd_ready = 0;
        chk("post_flush_empty", 32'(a_empty), 32'd1);

        // B: registered output, latency and capacity
        b_wr_valid = 1;
        b_wr_data = 32'h11;
        tick();
        chk("oreg_lat1_valid", 32'(b_rd_valid), 32'd0);
        chk("oreg_lat1_ocup", 32'(b_ocup), 32'd1);
        b_wr_data = 32'h12;
        tick();
        chk("oreg_lat2_valid", 32'(b_rd_valid), 32'd1);
        chk("oreg_lat2_data", b_rd_data, 32'h11);
        chk("oreg_lat2_ocup", 32'(b_ocup), 32'd2);
        for (int i = 0; i < 3; i++) begin
            b_wr_data = 32'h13 + 32'(i);
            chk("oreg_fill_full", 32'(b_full), 32'd0);
            tick();
            chk("oreg_fill_ocup", 32'(b_ocup), 32'(i + 3));
        end
        chk("oreg_full", 32'(b_full), 32'd1);
        chk("oreg_full_wr_ready", 32'(b_wr_ready), 32'd0);
        chk("oreg_full_free", 32'(b_free), 32'd0);
        chk("oreg_afull", 32'(b_afull), 32'd1);
        b_wr_data = 32'h99;
        tick();
        b_wr_valid = 0;
        chk("oreg_drop_ocup", 32'(b_ocup), 32'd5);

        // B: backpressure hold
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_valid", 32'(b_rd_valid), 32'd1);
            chk("bp_data", b_rd_data, 32'h11);
        end

        // B: drain without bubbles
        b_rd_ready = 1;
        for (int i = 0; i < 5; i++) begin
            chk("oreg_drain_valid", 32'(b_rd_valid), 32'd1);
            chk("oreg_drain_data", b_rd_data, 32'h11 + 32'(i));
            tick();
        end
        chk("oreg_drain_empty", 32'(b_empty), 32'd1);
        chk("oreg_drain_valid0", 32'(b_rd_valid), 32'd0);

        // B: streaming from empty
        b_wr_valid = 1;
        for (int i = 0; i < 8; i++) begin
            b_wr_data = 32'h20 + 32'(i);
            tick();
            if (i == 0) chk("strm_first", 32'(b_rd_valid), 32'd0);
            else begin
                chk("strm_valid", 32'(b_rd_valid), 32'd1);
                chk("strm_data", b_rd_data, 32'h20 + 32'(i - 1));
            end
        end
        b_wr_valid = 0;
        tick();
        chk("strm_tail", b_rd_data, 32'h27);
        tick();
        b_rd_ready = 0;
        chk("strm_empty", 32'(b_empty), 32'd1);

        // asynchronous reset mid-burst
        a_wr_valid = 1;
        b_wr_valid = 1;
        for (int i = 0; i < 3; i++) begin
            a_wr_data = 32'h50 + 32'(i);
            b_wr_data = 32'h60 + 32'(i);
            tick();
        end
        chk("burst_b_ocup", 32'(b_ocup), 32'd3);
        chk("burst_b_valid", 32'(b_rd_valid), 32'd1);
        #1;
        rst = 0;
        #1;
        chk("arst_b_valid", 32'(b_rd_valid), 32'd0);
        chk("arst_b_ocup", 32'(b_ocup), 32'd0);
        chk("arst_b_empty", 32'(b_empty), 32'd1);
        chk("arst_b_wr_ready", 32'(b_wr_ready), 32'd0);
        chk("arst_b_free", 32'(b_free), 32'd5);
        chk("arst_b_data", b_rd_data, 32'd0);
        chk("arst_a_ocup", 32'(a_ocup), 32'd0);
        chk("arst_a_aempty", 32'(a_aempty), 32'd1);
        a_wr_valid = 0;
        b_wr_valid = 0;
        tick();
        rst = 1;
        tick();
        chk("rerel_b_wr_ready", 32'(b_wr_ready), 32'd1);
        chk("rerel_a_empty", 32'(a_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_fifo_hs.md
Name: dma_fifo_hs

Overview:
- Next-generation DMA data buffer. Ready/valid handshake on both sides; no silent drop or underflow.
- Depth need not be a power of 2. Optional registered output stage; programmable almost-full/almost-empty flags; synchronous flush.
- Sits between the AXI read-data path and the AXI write-data path of the DMA streamer; replaces the plain write/read-strobe FIFO in new channels.

Parameters:
- SLOTS, `DMA_FIFO_DEPTH: storage-array entries, any integer >= 2.
- WIDTH, `DMA_DATA_WIDTH: data bits per entry.
- OUT_REG, 0: 1 adds a registered output stage. Total capacity CAP = SLOTS + OUT_REG.
- AF_THRESH, CAP-1: almost_full_o asserts when ocup >= AF_THRESH; legal range 1..CAP.
- AE_THRESH, 1: almost_empty_o asserts when ocup <= AE_THRESH; legal range 0..CAP-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous clear of all contents
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  space available (= ~full, ~flush_i)
- wr_data_i  in  WIDTH  write data
- rd_valid_o  out  1  head entry valid
- rd_ready_i  in  1  consumer accepts head
- rd_data_o  out  WIDTH  head data; '0 when rd_valid_o=0
- full_o  out  1  ocup == CAP
- empty_o  out  1  ocup == 0
- almost_full_o  out  1  ocup >= AF_THRESH
- almost_empty_o  out  1  ocup <= AE_THRESH
- ocup_o  out  $clog2(CAP+1)  entries held, including the output stage
- free_o  out  $clog2(CAP+1)  CAP - ocup

Behaviour:
- Reset (rst=0, asynchronous): pointers=0, count=0, output stage invalid.
  - Outputs during reset: wr_ready_o=0, rd_valid_o=0, empty_o=1, full_o=0, ocup_o=0, free_o=CAP, almost_empty_o=1.
  - Outputs first cycle after release: wr_ready_o=1.
  - Array contents are not reset.
- Write accept: wr_valid_i & wr_ready_o at a posedge. wr_ready_o depends only on registered state and flush_i; no combinational path from rd_ready_i.
- When full, no write is accepted even if a read completes in the same cycle.
- Read accept: rd_valid_o & rd_ready_i at a posedge.
- Pointers: wr_ptr and rd_ptr each range 0..SLOTS-1. Increment wraps explicitly SLOTS-1 -> 0 (no power-of-2 masking).
- Count: separate array-count register, width $clog2(SLOTS+1).
  - Simultaneous accepted write and read: count unchanged, both pointers advance.
- OUT_REG=0, fall-through:
  - rd_valid_o = (count != 0); rd_data_o = array[rd_ptr], combinational from registered state.
  - Write-to-rd_valid_o latency: 1 cycle. No same-cycle bypass when empty.
- OUT_REG=1:
  - Output stage out_vld/out_data is loaded from array[rd_ptr] when (~out_vld | rd_ready_i) and count != 0.
  - rd_valid_o = out_vld; rd_data_o = out_data.
  - Write-to-rd_valid_o latency: 2 cycles. Back-to-back streaming is sustained at 1 entry/cycle.
  - ocup = count + out_vld.
- Flags are combinational from registered count/out_vld (registered-state timing only).
- flush_i=1 at a posedge: count=0, pointers=0, out_vld=0. Any handshake in that cycle is ignored and wr_ready_o=0 during flush_i.
  - Next cycle: empty_o=1, rd_valid_o=0.
- rd_data_o is driven '0 whenever rd_valid_o=0. Verification checks this.
- Elaboration assertions (guarded by NO_ASSERTIONS): SLOTS >= 2, 1 <= AF_THRESH <= CAP, 0 <= AE_THRESH < CAP.
- Bench protocol check: once rd_valid_o rises, it and rd_data_o remain stable until rd_ready_i, except on flush_i.

Decomposition:
- dma_utils_pkg gains a function fifo_cnt_w(int cap) returning $clog2(cap+1), used for ocup/free widths by this block and its instantiators.
- Defaults stay as the existing `DMA_FIFO_DEPTH/`DMA_DATA_WIDTH macros.
- One natural sub-module: dma_fifo_out_stage (single-entry valid/ready register, reset to invalid, with flush), instantiated when OUT_REG=1 via generate.

Test Plan:
- Reset/idle: SLOTS=5, WIDTH=32, OUT_REG=0. Hold rst=0 -> wr_ready_o=0, empty_o=1, free_o=5. Release -> wr_ready_o=1 next cycle.
- Fill/wrap, non-power-of-2 depth: SLOTS=5. Write 0xA0..0xA4 -> full_o=1, wr_ready_o=0, almost_full_o=1 from ocup=4. Write 0xA5 while full -> not accepted. Read 3, write 0xA5..0xA7 -> read order A3,A4,A5,A6,A7 with ptr wrap 4->0.
- Simultaneous: ocup=3, wr and rd accepted every cycle for 10 cycles -> ocup_o stays 3, data order preserved. At full with rd_ready_i=1, wr not accepted that cycle.
- OUT_REG=1, SLOTS=4: write 0x11 at cycle 0 -> rd_valid_o at cycle 2. CAP=5 entries accepted before full_o. Continuous rd_ready_i=1 -> 1 word/cycle, no bubbles.
- Backpressure: rd_ready_i=0 for 6 cycles with rd_valid_o=1 -> rd_data_o stable. rd_data_o='0 whenever rd_valid_o=0.
- Flush and reset mid-stream: ocup=3, flush_i=1 together with wr_valid_i -> next cycle ocup_o=0, write dropped. Asserting rst mid-burst clears all outputs immediately, without waiting for a clock edge.
